// File: rtl/retire_monitor.sv
// Run monitor on the hart retire stream: cycle/instret/trap counters, halt detection, watchdog.
// Optional load/store/control-flow class counters are built when RETIRE_MONITOR_CLASS_EN is defined.
module retire_monitor #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned TIMEOUT   = 40000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_retire_valid,
   input  logic [31:0]          i_retire_inst,
   input  logic                 i_retire_trap,
   input  logic                 i_retire_halt,
   input  logic                 i_retire_dmem_ren,
   input  logic                 i_retire_dmem_wen,
   output logic [1:0]           o_state,
   output logic [CNT_WIDTH-1:0] o_cycles,
   output logic [CNT_WIDTH-1:0] o_instret,
   output logic [CNT_WIDTH-1:0] o_traps,
   output logic [CNT_WIDTH-1:0] o_loads,
   output logic [CNT_WIDTH-1:0] o_stores,
   output logic [CNT_WIDTH-1:0] o_ctrl,
   output logic                 o_done,
   output logic                 o_timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_DONE    = 2'd2,
      S_TIMEOUT = 2'd3
   } state_e;

   // Watchdog compare is done one bit wider than either operand so TIMEOUT never truncates.
   localparam int unsigned          XW      = (CNT_WIDTH >= 32) ? CNT_WIDTH + 1 : 33;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [XW-1:0]        TMO_X   = XW'(TIMEOUT);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic                 en);
      sat_inc = (en && !(&v)) ? v + CNT_ONE : v;
   endfunction

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic [CNT_WIDTH-1:0] traps_q, traps_d;
   logic                 done_q, done_d;
   logic                 tmo_q, tmo_d;
   logic [CNT_WIDTH-1:0] cyc_inc;
   logic [XW-1:0]        cyc_x;
   logic                 clr;
   logic                 ret;

   assign cyc_inc = sat_inc(cycles_q, 1'b1);
   assign cyc_x   = XW'(cyc_inc);

   always_comb begin
      state_d  = state_q;
      cycles_d = cycles_q;
      clr      = 1'b0;
      ret      = 1'b0;
      case (state_q)
         S_RUN: begin
            cycles_d = cyc_inc;
            ret      = i_retire_valid;
            // Halt takes priority over the watchdog in the same cycle.
            if (i_retire_valid && i_retire_halt)
               state_d = S_DONE;
            else if (cyc_x > TMO_X)
               state_d = S_TIMEOUT;
         end
         default: begin
            if (i_start) begin
               clr      = 1'b1;
               cycles_d = '0;
               state_d  = S_RUN;
            end
         end
      endcase
   end

   always_comb begin
      instret_d = clr ? '0 : sat_inc(instret_q, ret);
      traps_d   = clr ? '0 : sat_inc(traps_q, ret && i_retire_trap);
      done_d    = (state_d == S_DONE);
      tmo_d     = (state_d == S_TIMEOUT);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         cycles_q  <= '0;
         instret_q <= '0;
         traps_q   <= '0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cycles_q  <= cycles_d;
         instret_q <= instret_d;
         traps_q   <= traps_d;
         done_q    <= done_d;
         tmo_q     <= tmo_d;
      end
   end

   assign o_state   = state_q;
   assign o_cycles  = cycles_q;
   assign o_instret = instret_q;
   assign o_traps   = traps_q;
   assign o_done    = done_q;
   assign o_timeout = tmo_q;

`ifdef RETIRE_MONITOR_CLASS_EN
   logic [CNT_WIDTH-1:0] loads_q, loads_d;
   logic [CNT_WIDTH-1:0] stores_q, stores_d;
   logic [CNT_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [6:0]           opc;
   logic                 is_ctrl;
   logic                 unused_inst;

   assign opc         = i_retire_inst[6:0];
   assign unused_inst = ^i_retire_inst[31:7];
   // BRANCH, JAL, JALR major opcodes.
   assign is_ctrl     = (opc == 7'b1100011) || (opc == 7'b1101111) || (opc == 7'b1100111);

   always_comb begin
      loads_d  = clr ? '0 : sat_inc(loads_q, ret && i_retire_dmem_ren);
      stores_d = clr ? '0 : sat_inc(stores_q, ret && i_retire_dmem_wen);
      ctrl_d   = clr ? '0 : sat_inc(ctrl_q, ret && is_ctrl);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         loads_q  <= '0;
         stores_q <= '0;
         ctrl_q   <= '0;
      end else begin
         loads_q  <= loads_d;
         stores_q <= stores_d;
         ctrl_q   <= ctrl_d;
      end
   end

   assign o_loads  = loads_q;
   assign o_stores = stores_q;
   assign o_ctrl   = ctrl_q;
`else
   logic unused_class;

   assign unused_class = ^{i_retire_inst, i_retire_dmem_ren, i_retire_dmem_wen};
   assign o_loads      = '0;
   assign o_stores     = '0;
   assign o_ctrl       = '0;
`endif

endmodule
